// File: rtl/spi_xfer_sequencer.sv
// spi_xfer_sequencer
// Turns one host read/write request into a two-word frame (command word, then
// data word) on a 16-bit SPI master word engine. It handshakes with the master
// through Go/Busy, captures Rx_word for reads and returns a one-cycle Done
// pulse. Err is set alongside Done if a per-word watchdog expires.
//
// Ports
//   CLK, RST          clock, asynchronous active-high reset
//   Req, Wr, Addr,    host request; Wr/Addr/Wdata are captured with Req,
//   Wdata             and Req is sampled only while idle
//   Ready             high only while idle
//   Done, Err         one-cycle completion pulse; Err=1 means watchdog expiry
//   Rdata             read data, valid from Done until the next read's Done
//   Go, Tx_word       to the master
//   Busy, Rx_word     from the master (Busy is synchronous to CLK)
module spi_xfer_sequencer #(
    parameter int unsigned ADDR_W    = 15,
    parameter int unsigned TO_CYCLES = 1023,
    parameter logic [15:0] RD_DUMMY  = 16'h0000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Req,
    input  logic              Wr,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [15:0]       Wdata,
    output logic              Ready,
    output logic              Done,
    output logic              Err,
    output logic [15:0]       Rdata,
    output logic              Go,
    output logic [15:0]       Tx_word,
    input  logic              Busy,
    input  logic [15:0]       Rx_word
);

    localparam logic [9:0] WD_LIM = 10'(TO_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE, S_C_GO, S_C_WAIT, S_GAP, S_D_GO, S_D_WAIT, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        wr_q, wr_d;
    logic [14:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [9:0]  wd_q, wd_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [15:0] rdata_q, rdata_d;
    logic        go_q, go_d;
    logic [15:0] tx_q, tx_d;

    logic        wd_hit;
    assign wd_hit = (wd_q == WD_LIM);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wd_q    <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            go_q    <= 1'b0;
            tx_q    <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wd_q    <= wd_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            go_q    <= go_d;
            tx_q    <= tx_d;
        end
    end

    // Every output is a register, so the values computed here appear one
    // cycle later: Go rises the cycle after a *_GO state is entered, which is
    // what keeps Tx_word loaded one cycle ahead of Go.
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wd_d    = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        go_d    = 1'b0;
        tx_d    = tx_q;

        unique case (state_q)
            S_IDLE: begin
                if (Req) begin
                    wr_d    = Wr;
                    addr_d  = 15'(Addr);
                    wdata_d = Wdata;
                    tx_d    = {Wr, 15'(Addr)};
                    state_d = S_C_GO;
                end
            end
            S_C_GO, S_D_GO: begin
                wd_d = wd_q + 10'd1;
                if (wd_hit) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (Busy) begin
                    // Master has taken the word; drop Go and wait for it to finish.
                    state_d = (state_q == S_C_GO) ? S_C_WAIT : S_D_WAIT;
                end else begin
                    go_d = 1'b1;
                end
            end
            S_C_WAIT: begin
                wd_d = wd_q + 10'd1;
                if (wd_hit) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (!Busy) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                // Master is in its finish cycle here and would ignore Go.
                tx_d    = wr_q ? wdata_q : RD_DUMMY;
                state_d = S_D_GO;
            end
            S_D_WAIT: begin
                wd_d = wd_q + 10'd1;
                if (wd_hit) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (!Busy) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                    if (!wr_q) rdata_d = Rx_word;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE);
    end

    assign Ready   = ready_q;
    assign Done    = done_q;
    assign Err     = err_q;
    assign Rdata   = rdata_q;
    assign Go      = go_q;
    assign Tx_word = tx_q;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Directed bench for spi_xfer_sequencer with a small behavioural SPI master:
// it samples Go while idle, raises Busy, latches Tx_word one cycle later,
// holds Busy for mb cycles, then spends one finish cycle before idling.
// The command slot returns 16'hFFFF on Rx_word, the data slot RX_DATA.
module tb_spi_xfer_sequencer;

    localparam logic [15:0] RX_DATA = 16'h5A5A;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        Req = 1'b0;
    logic        Wr  = 1'b0;
    logic [14:0] Addr  = '0;
    logic [15:0] Wdata = '0;
    logic        Ready, Done, Err, Go;
    logic [15:0] Rdata, Tx_word;
    logic        Busy;
    logic [15:0] Rx_word;

    spi_xfer_sequencer #(.ADDR_W(15), .TO_CYCLES(8), .RD_DUMMY(16'h0000)) dut (
        .CLK(CLK), .RST(RST), .Req(Req), .Wr(Wr), .Addr(Addr), .Wdata(Wdata),
        .Ready(Ready), .Done(Done), .Err(Err), .Rdata(Rdata),
        .Go(Go), .Tx_word(Tx_word), .Busy(Busy), .Rx_word(Rx_word)
    );

    always #5 CLK = ~CLK;

    // ---------------- master model ----------------
    int          mb = 4;
    logic        m_dis = 1'b0;
    logic [1:0]  m_st;
    int          m_cnt;
    int          m_wc;
    logic        m_lat;
    logic [15:0] lat_q[$];

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            Busy <= 1'b0; Rx_word <= '0; m_st <= 2'd0; m_cnt <= 0; m_wc <= 0; m_lat <= 1'b0;
        end else if (m_dis) begin
            Busy <= 1'b0; m_st <= 2'd0;
        end else begin
            case (m_st)
                2'd0: if (Go) begin
                    Busy <= 1'b1; m_cnt <= mb - 1; m_st <= 2'd1; m_lat <= 1'b1;
                end
                2'd1: begin
                    if (m_lat) begin lat_q.push_back(Tx_word); m_lat <= 1'b0; end
                    if (m_cnt == 0) begin
                        Busy <= 1'b0; m_st <= 2'd2; m_wc <= m_wc + 1;
                        Rx_word <= m_wc[0] ? RX_DATA : 16'hFFFF;
                    end else m_cnt <= m_cnt - 1;
                end
                default: m_st <= 2'd0;
            endcase
        end
    end

    // ---------------- protocol monitor ----------------
    int          go_rise = 0, done_cnt = 0, go_hi = 0;
    int          v_drop = 0, v_fin = 0, v_gap = 0, v_tx = 0;
    int          since_fall = 100;
    logic        prev_go = 1'b0, prev_busy = 1'b0;
    logic [15:0] prev_tx = '0, tx_hold = '0;

    always @(negedge CLK) begin
        if (!RST) begin
            if (Go && !prev_go) begin
                go_rise <= go_rise + 1;
                tx_hold <= Tx_word;
                if (Tx_word !== prev_tx) v_tx <= v_tx + 1;
            end
            if (Go && prev_go && Tx_word !== tx_hold) v_tx <= v_tx + 1;
            if (Go) go_hi <= go_hi + 1;
            if (prev_go && prev_busy && Go) v_drop <= v_drop + 1;
            if (Go && m_st == 2'd2) v_fin <= v_fin + 1;
            if (Go && ((prev_busy && !Busy) || since_fall <= 1)) v_gap <= v_gap + 1;
            since_fall <= (prev_busy && !Busy) ? 0 : ((since_fall < 100) ? since_fall + 1 : 100);
            if (Done) done_cnt <= done_cnt + 1;
        end
        prev_go   <= Go;
        prev_busy <= Busy;
        prev_tx   <= Tx_word;
    end

    // ---------------- checking ----------------
    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Issues one request and waits (bounded) for Done. lat counts clock edges
    // from the edge that samples Req (=1) to the edge that raises Done.
    task automatic xfer(input logic wr, input logic [14:0] a, input logic [15:0] d,
                        output int lat, output logic ok, output logic err,
                        output logic [15:0] rd, output logic rdy_mid);
        for (int i = 0; i < 50 && !Ready; i++) @(posedge CLK);
        @(negedge CLK);
        Req = 1'b1; Wr = wr; Addr = a; Wdata = d;
        @(posedge CLK); #1;
        Req = 1'b0;
        rdy_mid = Ready;
        lat = 1; ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (Done) begin ok = 1'b1; break; end
            @(posedge CLK); #1;
            lat++;
        end
        err = Err;
        rd  = Rdata;
    endtask

    int          lat, g0, d0, h0, nd, gap, since_done;
    logic        ok, err, rdy;
    logic [15:0] rd;

    initial begin
        // reset state
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_ready", Ready, 1); chk("rst_done", Done, 0); chk("rst_err", Err, 0);
        chk("rst_rdata", Rdata, 0); chk("rst_go", Go, 0); chk("rst_tx", Tx_word, 0);
        RST = 1'b0;
        repeat (2) @(posedge CLK);

        // write
        lat_q.delete(); g0 = go_rise;
        xfer(1'b1, 15'h0123, 16'hBEEF, lat, ok, err, rd, rdy);
        chk("wr_done", ok, 1); chk("wr_err", err, 0); chk("wr_rdy_mid", rdy, 0);
        chk("wr_lat", lat, 2 * mb + 8); chk("wr_rdata", rd, 16'h0000);
        @(posedge CLK); #1;
        chk("wr_ready_after", Ready, 1); chk("wr_done_pulse", Done, 0);
        chk("wr_go_cnt", go_rise - g0, 2); chk("wr_nwords", lat_q.size(), 2);
        if (lat_q.size() == 2) begin chk("wr_cmd", lat_q[0], 16'h8123); chk("wr_data", lat_q[1], 16'hBEEF); end
        repeat (5) @(posedge CLK);

        // read
        lat_q.delete(); g0 = go_rise;
        xfer(1'b0, 15'h0123, 16'h1111, lat, ok, err, rd, rdy);
        chk("rd_done", ok, 1); chk("rd_err", err, 0); chk("rd_rdata", rd, RX_DATA);
        @(posedge CLK); #1;
        chk("rd_ready_after", Ready, 1); chk("rd_go_cnt", go_rise - g0, 2);
        chk("rd_nwords", lat_q.size(), 2);
        if (lat_q.size() == 2) begin chk("rd_cmd", lat_q[0], 16'h0123); chk("rd_dummy", lat_q[1], 16'h0000); end
        repeat (5) @(posedge CLK);

        // Req pulsed during C_WAIT is ignored
        lat_q.delete(); g0 = go_rise; d0 = done_cnt;
        @(negedge CLK); Req = 1'b1; Wr = 1'b0; Addr = 15'h0042;
        @(posedge CLK); #1; Req = 1'b0;
        for (int i = 0; i < 50 && !Busy; i++) begin @(posedge CLK); #1; end
        @(posedge CLK); #1;
        Req = 1'b1; Wr = 1'b1; Addr = 15'h7FFF;
        @(posedge CLK); #1; Req = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin if (Done) begin ok = 1'b1; break; end @(posedge CLK); #1; end
        chk("ign_done", ok, 1);
        repeat (20) @(posedge CLK);
        chk("ign_done_cnt", done_cnt - d0, 1); chk("ign_go_cnt", go_rise - g0, 2);
        chk("ign_rdata", Rdata, RX_DATA);
        if (lat_q.size() >= 1) chk("ign_cmd", lat_q[0], 16'h0042);

        // Req held high: two back-to-back writes
        lat_q.delete(); g0 = go_rise; d0 = done_cnt; nd = 0; gap = -1; since_done = -1;
        @(negedge CLK); Req = 1'b1; Wr = 1'b1; Addr = 15'h0001; Wdata = 16'hCAFE;
        for (int i = 0; i < 300; i++) begin
            @(posedge CLK); #1;
            if (since_done >= 0) since_done++;
            if (Go && nd == 1 && gap < 0) gap = since_done;
            if (Done) begin
                nd++;
                since_done = 0;
                if (nd == 2) begin Req = 1'b0; break; end
            end
        end
        repeat (20) @(posedge CLK);
        chk("b2b_done_cnt", done_cnt - d0, 2); chk("b2b_go_cnt", go_rise - g0, 4);
        chk("b2b_gap", gap, 3); chk("b2b_nwords", lat_q.size(), 4);

        // longest master frame that still fits the watchdog
        mb = 5; g0 = go_rise;
        xfer(1'b1, 15'h0010, 16'h0F0F, lat, ok, err, rd, rdy);
        chk("wd5_done", ok, 1); chk("wd5_err", err, 0); chk("wd5_lat", lat, 2 * 5 + 8);
        repeat (10) @(posedge CLK);
        chk("wd5_go_cnt", go_rise - g0, 2);

        // watchdog with Busy tied low
        m_dis = 1'b1; mb = 4; g0 = go_rise; h0 = go_hi;
        xfer(1'b0, 15'h0020, 16'h0000, lat, ok, err, rd, rdy);
        chk("wdt_done", ok, 1); chk("wdt_err", err, 1); chk("wdt_lat", lat, 10);
        chk("wdt_rdata", rd, RX_DATA);
        @(posedge CLK); #1;
        chk("wdt_ready", Ready, 1); chk("wdt_err_pulse", Err, 0);
        chk("wdt_go_hi", go_hi - h0, 8); chk("wdt_go_cnt", go_rise - g0, 1);
        m_dis = 1'b0;
        repeat (5) @(posedge CLK);

        // watchdog expiring in C_WAIT (master frame one cycle too long)
        mb = 6; g0 = go_rise;
        xfer(1'b1, 15'h0030, 16'h3333, lat, ok, err, rd, rdy);
        chk("wd6_done", ok, 1); chk("wd6_err", err, 1); chk("wd6_lat", lat, 10);
        repeat (10) @(posedge CLK);
        chk("wd6_go_cnt", go_rise - g0, 1);
        mb = 4;

        // reset in D_WAIT
        g0 = go_rise; d0 = done_cnt;
        @(negedge CLK); Req = 1'b1; Wr = 1'b0; Addr = 15'h0055;
        @(posedge CLK); #1; Req = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (go_rise - g0 == 2 && Busy) begin ok = 1'b1; break; end
            @(posedge CLK); #1;
        end
        chk("rst_reach_dwait", ok, 1);
        @(posedge CLK); #1;
        chk("rst_pre_rdata", Rdata, RX_DATA); chk("rst_pre_ready", Ready, 0);
        RST = 1'b1; #1;
        chk("rstm_ready", Ready, 1); chk("rstm_done", Done, 0); chk("rstm_err", Err, 0);
        chk("rstm_rdata", Rdata, 0); chk("rstm_go", Go, 0); chk("rstm_tx", Tx_word, 0);
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        repeat (5) @(posedge CLK);
        chk("rstm_no_done", done_cnt - d0, 0);

        // normal write after reset
        lat_q.delete();
        xfer(1'b1, 15'h7FFF, 16'h1234, lat, ok, err, rd, rdy);
        chk("post_done", ok, 1); chk("post_err", err, 0); chk("post_lat", lat, 2 * mb + 8);
        repeat (5) @(posedge CLK);
        chk("post_nwords", lat_q.size(), 2);
        if (lat_q.size() == 2) begin chk("post_cmd", lat_q[0], 16'hFFFF); chk("post_data", lat_q[1], 16'h1234); end

        // protocol rules over the whole run
        chk("go_drop_after_busy", v_drop, 0);
        chk("go_in_master_fin", v_fin, 0);
        chk("go_in_gap", v_gap, 0);
        chk("tx_stable", v_tx, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, limit 500000");
        $fatal(1);
    end

endmodule

// File: doc/spi_xfer_sequencer.md
Name: spi_xfer_sequencer

Overview:
Host-side transaction controller placed directly upstream of the 16-bit SPI master word engine. It turns one host read or write request into a two-word SPI frame: a command word, then a data word. It drives the master's Go/Tx_word inputs, tracks its Busy output and captures Rx_word. It returns read data, or an error if the master does not respond, to the host with a single-cycle done pulse.

Parameters:
ADDR_W, 15, host address width; must be at most 15. Address is zero-extended into the command word.
TO_CYCLES, 1023, per-word watchdog limit in CLK cycles, counted from the first Go cycle; must be at most 1023.
RD_DUMMY, 16'h0000, Tx word sent in the data slot of a read.

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous, active-high reset
Req  in  1  host request; sampled only in IDLE
Wr  in  1  1 = write, 0 = read; captured with Req
Addr  in  ADDR_W  target address; captured with Req
Wdata  in  16  write data; captured with Req
Ready  out  1  high in IDLE only
Done  out  1  one-cycle pulse at end of transaction
Err  out  1  valid with Done; 1 = watchdog expired
Rdata  out  16  read data; valid from Done until next read's Done
Go  out  1  to master Go
Tx_word  out  16  to master Tx_word
Busy  in  1  from master Busy
Rx_word  in  16  from master Rx_word

Behaviour:
- Reset values: Ready=1, Done=0, Err=0, Rdata=0, Go=0, Tx_word=0. FSM goes to IDLE, captured registers and watchdog clear. Reset mid-frame aborts immediately, with no Done. A master frame already in progress is not waited for.
- Command word = {Wr, zero-extended Addr[14:0]}. Data word = captured Wdata on a write, RD_DUMMY on a read.
- All outputs are registered. Tx_word is loaded one cycle before Go rises and held constant until Busy has been seen high. The master latches Tx_word one cycle after it samples Go.
- FSM states:
  - IDLE: Req=1 → capture Wr/Addr/Wdata, load command word into Tx_word → C_GO.
  - C_GO: Go=1, held until Busy=1 is sampled, then Go=0 → C_WAIT.
  - C_WAIT: on Busy=0 → GAP. The master spends one cycle in its finish state and ignores Go there, so the mandatory GAP state is required.
  - GAP: one cycle, load data word into Tx_word → D_GO.
  - D_GO: same rules as C_GO → D_WAIT.
  - D_WAIT: on Busy=0 → DONE. If the frame is a read, Rdata<=Rx_word in the same cycle.
  - DONE: Done=1, Err=0 for one cycle → IDLE. IDLE then enforces at least one further cycle before the next Go.
- Watchdog:
  - A 10-bit counter clears on entry to C_GO or D_GO and increments each cycle in *_GO and *_WAIT.
  - Reaching TO_CYCLES → Go=0, Done=1 and Err=1 for one cycle → IDLE.
  - Rdata is unchanged on error. The rest of the frame is abandoned.
- Req asserted outside IDLE is ignored and not queued. Req held high in IDLE back-to-back starts a new transaction on the cycle after DONE returns to IDLE.
- Busy is assumed synchronous to CLK.
- Minimum transaction latency against the master: Done comes about 2 × 135 cycles after Req. Exact latency = command frame + data frame + 4 control cycles. The bench measures it; it is not hard-coded.

Test Plan:
- Write: Req with Wr=1, Addr=15'h0123, Wdata=16'hBEEF → master sees Tx_word 16'h8123 then 16'hBEEF. Exactly two Go pulses; Done=1, Err=0; Rdata stays 16'h0000.
- Read against a slave model returning 16'h5A5A in the data slot → Tx_word 16'h0123 then 16'h0000. Rdata=16'h5A5A when Done pulses; Ready returns to 1 the next cycle.
- Go/Busy timing: check Go drops the cycle after Busy is sampled high. Check Go is never high during the master finish cycle or in GAP. Check Tx_word is stable from one cycle before Go until Busy rises.
- Watchdog: tie Busy=0 with TO_CYCLES=8 → Go high for 8 cycles, then Done=1 and Err=1. Rdata unchanged; Ready=1 afterwards.
- Req pulsed during C_WAIT is ignored: only one Done. Req held high continuously → back-to-back transactions with at least one IDLE cycle between Done and the next Go.
- RST asserted in D_WAIT → all outputs take their reset values immediately; no Done. A new Req after release completes normally.
